// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register serial controller:
// datapath mode encodings and the sequencer state type.
package usr_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/usr_datapath.sv
// N-bit universal shift register: hold, shift right (si into MSB),
// shift left (si into LSB) or parallel load, with synchronous reset.
module usr_datapath
    import usr_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   mode,
    input  logic         si,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [N-1:0] q_r;

    // Register update selected by the two-bit mode code
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= {N{1'b0}};
        end else begin
            case (mode)
                MODE_HOLD: q_r <= q_r;
                MODE_SHR:  q_r <= {si, q_r[N-1:1]};
                MODE_SHL:  q_r <= {q_r[N-2:0], si};
                MODE_LOAD: q_r <= d;
                default:   q_r <= q_r;
            endcase
        end
    end

    assign q = q_r;

endmodule

// File: rtl/usr_serial_ctrl.sv
// Full-duplex serial transfer engine: loads a word, shifts it out MSB- or
// LSB-first at CLKS_PER_BIT clocks per bit while capturing sin, then strobes rx_valid.
module usr_serial_ctrl
    import usr_pkg::*;
#(
    parameter int N            = 4,
    parameter int CLKS_PER_BIT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] tx_data,
    input  logic         tx_valid,
    output logic         tx_ready,
    input  logic         dir,
    input  logic         pause,
    input  logic         sin,
    output logic         sout,
    output logic         busy,
    output logic [N-1:0] rx_data,
    output logic         rx_valid
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
    localparam logic [CW-1:0] COUNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

    state_t        state_r;
    state_t        state_nxt_s;
    logic [TW-1:0] timer_r;
    logic [TW-1:0] timer_nxt_s;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic          dir_r;
    logic          dir_nxt_s;
    logic [1:0]    mode_s;
    logic [N-1:0]  q_s;

    // Sequencer state, bit timer, bit counter and latched direction
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            timer_r <= {TW{1'b0}};
            count_r <= {CW{1'b0}};
            dir_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            timer_r <= timer_nxt_s;
            count_r <= count_nxt_s;
            dir_r   <= dir_nxt_s;
        end
    end

    // Next-state and datapath mode; pause in SHIFT freezes everything
    always_comb begin
        state_nxt_s = state_r;
        timer_nxt_s = timer_r;
        count_nxt_s = count_r;
        dir_nxt_s   = dir_r;
        mode_s      = MODE_HOLD;
        case (state_r)
            ST_IDLE: begin
                if (tx_valid) begin
                    mode_s      = MODE_LOAD;
                    dir_nxt_s   = dir;
                    timer_nxt_s = {TW{1'b0}};
                    count_nxt_s = {CW{1'b0}};
                    state_nxt_s = ST_SHIFT;
                end else begin
                    mode_s      = MODE_HOLD;
                end
            end
            ST_SHIFT: begin
                if (pause) begin
                    mode_s = MODE_HOLD;
                end else if (timer_r == TIMER_LAST) begin
                    mode_s      = dir_r ? MODE_SHR : MODE_SHL;
                    timer_nxt_s = {TW{1'b0}};
                    count_nxt_s = count_r + COUNT_ONE;
                    if (count_r == COUNT_LAST) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_SHIFT;
                    end
                end else begin
                    timer_nxt_s = timer_r + TIMER_ONE;
                    mode_s      = MODE_HOLD;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    usr_datapath #(
        .N (N)
    ) u_datapath (
        .clk  (clk),
        .rst  (rst),
        .mode (mode_s),
        .si   (sin),
        .d    (tx_data),
        .q    (q_s)
    );

    // Outputs decode from registered state only
    assign tx_ready = (state_r == ST_IDLE);
    assign busy     = (state_r == ST_SHIFT) || (state_r == ST_DONE);
    assign rx_valid = (state_r == ST_DONE);
    assign sout     = (state_r == ST_SHIFT) ? (dir_r ? q_s[0] : q_s[N-1]) : 1'b1;
    assign rx_data  = q_s;

endmodule

// File: tb/tb_usr_serial_ctrl.sv
// Directed self-checking bench for usr_serial_ctrl (N=4, CLKS_PER_BIT=2),
// plus a CLKS_PER_BIT=1 instance sharing the same inputs.
module tb_usr_serial_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] tx_data;
    logic       tx_valid;
    logic       dir;
    logic       pause;
    logic       sin;
    logic       tx_ready, sout, busy, rx_valid;
    logic [3:0] rx_data;
    logic       tx_ready1, sout1, busy1, rx_valid1;
    logic [3:0] rx_data1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    usr_serial_ctrl #(.N(4), .CLKS_PER_BIT(2)) u_dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .dir(dir), .pause(pause), .sin(sin),
        .sout(sout), .busy(busy), .rx_data(rx_data), .rx_valid(rx_valid)
    );

    usr_serial_ctrl #(.N(4), .CLKS_PER_BIT(1)) u_dut1 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready1), .dir(dir), .pause(pause), .sin(sin),
        .sout(sout1), .busy(busy1), .rx_data(rx_data1), .rx_valid(rx_valid1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; tx_valid = 1'b1; tx_data = 4'b1111; dir = 1'b0; pause = 1'b0; sin = 1'b1;
        tick(); tick();
        rst = 1'b0; tx_valid = 1'b0;
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b expected 1", tx_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        checks++; if (sout !== 1'b1) begin errors++; $display("FAIL reset_sout: got %b expected 1", sout); end
        checks++; if (rx_data !== 4'b0000) begin errors++; $display("FAIL reset_rx_data: got %b expected 0000", rx_data); end
        checks++; if (tx_ready1 !== 1'b1 || rx_data1 !== 4'b0000) begin errors++; $display("FAIL reset_dut1: got ready=%b data=%b expected 1/0000", tx_ready1, rx_data1); end
    endtask

    task automatic test_msb_first();
        logic [3:0] txw;
        logic [3:0] sinw;
        txw = 4'b1010; sinw = 4'b0110;
        tx_data = txw; dir = 1'b0; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0; tx_data = 4'b0000; dir = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sin = sinw[3-k];
            for (int c = 0; c < 2; c++) begin
                checks++; if (sout !== txw[3-k]) begin errors++; $display("FAIL msb_sout bit%0d cyc%0d: got %b expected %b", k, c, sout, txw[3-k]); end
                checks++; if (rx_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL msb_status bit%0d cyc%0d: got rx_valid=%b busy=%b expected 0/1", k, c, rx_valid, busy); end
                tick();
            end
        end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL msb_rx_valid: got %b expected 1", rx_valid); end
        checks++; if (rx_data !== 4'b0110) begin errors++; $display("FAIL msb_rx_data: got %b expected 0110", rx_data); end
        checks++; if (tx_ready !== 1'b0 || sout !== 1'b1) begin errors++; $display("FAIL msb_done: got ready=%b sout=%b expected 0/1", tx_ready, sout); end
        tick();
        checks++; if (rx_valid !== 1'b0 || tx_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL msb_idle: got rx_valid=%b ready=%b busy=%b expected 0/1/0", rx_valid, tx_ready, busy); end
        checks++; if (rx_data !== 4'b0110) begin errors++; $display("FAIL msb_rx_hold: got %b expected 0110", rx_data); end
        dir = 1'b0;
    endtask

    task automatic test_lsb_first();
        logic [3:0] txw;
        txw = 4'b1100;
        tx_data = txw; dir = 1'b1; tx_valid = 1'b1; sin = 1'b1;
        tick();
        tx_valid = 1'b0; dir = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 2; c++) begin
                checks++; if (sout !== txw[k]) begin errors++; $display("FAIL lsb_sout bit%0d cyc%0d: got %b expected %b", k, c, sout, txw[k]); end
                tick();
            end
        end
        checks++; if (rx_valid !== 1'b1 || rx_data !== 4'b1111) begin errors++; $display("FAIL lsb_done: got rx_valid=%b data=%b expected 1/1111", rx_valid, rx_data); end
        tick();
    endtask

    task automatic test_pause();
        logic [3:0] txw;
        logic [3:0] sinw;
        int ncyc;
        txw = 4'b1010; sinw = 4'b0110;
        tx_data = txw; dir = 1'b0; tx_valid = 1'b1; pause = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sin = sinw[3-k];
            ncyc = (k == 1) ? 5 : 2;
            for (int c = 0; c < ncyc; c++) begin
                pause = (k == 1 && c >= 1 && c <= 3);
                checks++; if (sout !== txw[3-k] || rx_valid !== 1'b0) begin errors++; $display("FAIL pause_cycle bit%0d cyc%0d: got sout=%b rx_valid=%b expected %b/0", k, c, sout, rx_valid, txw[3-k]); end
                tick();
            end
        end
        pause = 1'b1;
        checks++; if (rx_valid !== 1'b1 || rx_data !== 4'b0110) begin errors++; $display("FAIL pause_done: got rx_valid=%b data=%b expected 1/0110", rx_valid, rx_data); end
        tick();
        pause = 1'b0;
        checks++; if (tx_ready !== 1'b1 || rx_valid !== 1'b0) begin errors++; $display("FAIL pause_in_done: got ready=%b rx_valid=%b expected 1/0", tx_ready, rx_valid); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] txa;
        logic [3:0] txb;
        txa = 4'b1010; txb = 4'b0101;
        tx_data = txa; dir = 1'b0; tx_valid = 1'b1; sin = 1'b0;
        tick();
        tx_data = txb;
        for (int i = 0; i < 8; i++) begin
            checks++; if (tx_ready !== 1'b0 || sout !== txa[3-i/2]) begin errors++; $display("FAIL b2b_busy cyc%0d: got ready=%b sout=%b expected 0/%b", i, tx_ready, sout, txa[3-i/2]); end
            tick();
        end
        checks++; if (rx_valid !== 1'b1 || tx_ready !== 1'b0 || rx_data !== 4'b0000) begin errors++; $display("FAIL b2b_done: got rx_valid=%b ready=%b data=%b expected 1/0/0000", rx_valid, tx_ready, rx_data); end
        tick();
        checks++; if (tx_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got ready=%b busy=%b expected 1/0", tx_ready, busy); end
        tick();
        tx_valid = 1'b0;
        checks++; if (busy !== 1'b1 || sout !== 1'b0) begin errors++; $display("FAIL b2b_restart: got busy=%b sout=%b expected 1/0", busy, sout); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (sout !== txb[3-i/2]) begin errors++; $display("FAIL b2b_second cyc%0d: got sout=%b expected %b", i, sout, txb[3-i/2]); end
            tick();
        end
        checks++; if (rx_valid !== 1'b1 || rx_data !== 4'b0000) begin errors++; $display("FAIL b2b_second_done: got rx_valid=%b data=%b expected 1/0000", rx_valid, rx_data); end
        tick();
    endtask

    task automatic test_abort();
        logic seen;
        tx_data = 4'b1010; dir = 1'b0; tx_valid = 1'b1; sin = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (tx_ready !== 1'b1 || busy !== 1'b0 || sout !== 1'b1) begin errors++; $display("FAIL abort_state: got ready=%b busy=%b sout=%b expected 1/0/1", tx_ready, busy, sout); end
        checks++; if (rx_data !== 4'b0000) begin errors++; $display("FAIL abort_rx_data: got %b expected 0000", rx_data); end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            seen = seen | rx_valid;
            tick();
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_rx_valid: got %b expected 0", seen); end
        rst = 1'b1; tx_valid = 1'b1;
        tick();
        rst = 1'b0; tx_valid = 1'b0;
        checks++; if (busy !== 1'b0 || tx_ready !== 1'b1 || rx_data !== 4'b0000) begin errors++; $display("FAIL rst_vs_accept: got busy=%b ready=%b data=%b expected 0/1/0000", busy, tx_ready, rx_data); end
    endtask

    task automatic test_cpb1();
        logic [3:0] txw;
        logic [3:0] sinw;
        txw = 4'b1010; sinw = 4'b1001;
        tx_data = txw; dir = 1'b0; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sin = sinw[3-k];
            checks++; if (sout1 !== txw[3-k] || busy1 !== 1'b1 || rx_valid1 !== 1'b0) begin errors++; $display("FAIL cpb1_bit%0d: got sout=%b busy=%b rx_valid=%b expected %b/1/0", k, sout1, busy1, rx_valid1, txw[3-k]); end
            tick();
        end
        checks++; if (rx_valid1 !== 1'b1 || rx_data1 !== 4'b1001) begin errors++; $display("FAIL cpb1_done: got rx_valid=%b data=%b expected 1/1001", rx_valid1, rx_data1); end
        tick();
        checks++; if (tx_ready1 !== 1'b1 || sout1 !== 1'b1) begin errors++; $display("FAIL cpb1_idle: got ready=%b sout=%b expected 1/1", tx_ready1, sout1); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_pause();
        test_back_to_back();
        test_abort();
        test_cpb1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
